fir_decimator: RTL and testbench

Downstream stage of the FIR filter. Takes the 32-bit full-precision filter output, one sample per enabled clock, and keeps every DECIM-th sample. Kept samples are rounded and scaled back to 16 bits, then buffered in a small FIFO. The FIFO drains through a valid/ready interface toward the output sink (DAC/serializer), so a stalling sink never back-pressures the filter.

---
 rtl/fir_decimator.sv | 86 ++++++++
 tb/tb_fir_decimator.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fir_decimator.sv
// FIR output decimator: keeps every DECIM-th sample, rounds/scales to 16 bits, buffers in a FIFO.
// Build option: define DECIM_SAT_EN to clamp the scaled result instead of wrapping it.
module fir_decimator #(
    parameter int DECIM      = 4,
    parameter int SHIFT      = 15,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          CLK,
    input  logic                          rst_n,
    input  logic                          En_DEC,
    input  logic [31:0]                   sample_in,
    output logic [15:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic signed [32:0] HALF = 33'sd1 <<< (SHIFT - 1);

    logic [PW-1:0]        phase;
    logic                 keep;
    logic signed [32:0]   rnd_sum;
    logic signed [32:0]   r;
    logic [15:0]          scaled;
    logic                 stg_vld;
    logic [15:0]          stg_data;
    logic [15:0]          mem [FIFO_DEPTH];
    logic [AW:0]          wr_ptr, rd_ptr;
    logic                 full, push, pop;

    assign keep    = En_DEC && (phase == '0);
    assign rnd_sum = {sample_in[31], sample_in} + HALF;
    assign r       = rnd_sum >>> SHIFT;

`ifdef DECIM_SAT_EN
    always_comb begin
        scaled = r[15:0];
        if (r > 33'sd32767)
            scaled = 16'h7FFF;
        else if (r < -33'sd32768)
            scaled = 16'h8000;
    end
`else
    logic unused_r_hi;
    assign unused_r_hi = ^r[32:16];
    assign scaled      = r[15:0];
`endif

    // Extra wrap bit on each pointer lets level be a plain subtraction.
    assign fifo_level = wr_ptr - rd_ptr;
    assign out_valid  = (wr_ptr != rd_ptr);
    assign full       = (fifo_level == (AW+1)'(FIFO_DEPTH));
    assign pop        = out_valid && out_ready;
    assign push       = stg_vld && (!full || pop);
    assign out_data   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            phase    <= '0;
            stg_vld  <= 1'b0;
            stg_data <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= '0;
        end else begin
            if (En_DEC)
                phase <= (phase == PW'(DECIM - 1)) ? '0 : phase + 1'b1;
            stg_vld <= keep;
            if (keep)
                stg_data <= scaled;
            // On full+pop the write lands in the slot being vacated this edge.
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= stg_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (stg_vld && full && !pop)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator with a cycle-level scoreboard queue checked every cycle.
module tb_fir_decimator;
    localparam int DECIM = 4, SHIFT = 15, FIFO_DEPTH = 8;
    localparam logic [31:0] ROUND_IN  [4] = '{32'h00003FFF, 32'h00004000, 32'h00008000, 32'hFFFFC000};
    localparam logic [15:0] ROUND_EXP [4] = '{16'h0000, 16'h0001, 16'h0001, 16'h0000};
`ifdef DECIM_SAT_EN
    localparam logic [15:0] SAT_HI = 16'h7FFF, SAT_LO = 16'h8000;
`else
    localparam logic [15:0] SAT_HI = 16'h0000, SAT_LO = 16'h0000;
`endif

    logic        CLK = 1'b0, rst_n = 1'b0, En_DEC = 1'b0, out_ready = 1'b1;
    logic [31:0] sample_in = '0;
    logic [15:0] out_data;
    logic        out_valid, overflow;
    logic [$clog2(FIFO_DEPTH):0] fifo_level;

    fir_decimator #(.DECIM(DECIM), .SHIFT(SHIFT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .CLK(CLK), .rst_n(rst_n), .En_DEC(En_DEC), .sample_in(sample_in),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 CLK = ~CLK;

    int          checks = 0, errors = 0;
    logic [15:0] q[$];
    logic [15:0] seen[$];
    logic        m_stg_vld, m_ovf;
    logic [15:0] m_stg_data;
    int          m_phase;
    int          base;

    function automatic logic [15:0] scale(input logic [31:0] x);
        longint r;
        r = (longint'($signed(x)) + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
`ifdef DECIM_SAT_EN
        if (r > 32767) return 16'h7FFF;
        if (r < -32768) return 16'h8000;
`endif
        return r[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        q.delete();
        m_stg_vld  = 1'b0;
        m_stg_data = '0;
        m_phase    = 0;
        m_ovf      = 1'b0;
    endtask

    // Drive one cycle; at the falling edge compare DUT against the model, then advance the model.
    task automatic drive(input logic en, input logic [31:0] x);
        logic pop;
        En_DEC    = en;
        sample_in = x;
        @(negedge CLK);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("fifo_level", 32'(fifo_level), 32'(q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        pop = (q.size() != 0) && out_ready;
        if (pop) seen.push_back(q.pop_front());
        if (m_stg_vld) begin
            if (q.size() < FIFO_DEPTH) q.push_back(m_stg_data);
            else m_ovf = 1'b1;
        end
        m_stg_vld  = en && (m_phase == 0);
        m_stg_data = scale(x);
        if (en) m_phase = (m_phase + 1) % DECIM;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_seen(input string tag, input int b, input int first, input int n);
        chk({tag, "_count"}, 32'(seen.size() - b), 32'(n));
        for (int i = 0; i < n; i++)
            if (b + i < seen.size()) chk(tag, 32'(seen[b + i]), 32'(16'(first + i)));
    endtask

    initial begin
        model_clear();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_fifo_level", 32'(fifo_level), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            drive(1'b1, ROUND_IN[i]);
            drive(1'b1, 32'h0);
            chk("round_valid", 32'(out_valid), 32'd1);
            chk("round_data", 32'(out_data), 32'(ROUND_EXP[i]));
            drive(1'b1, 32'h0);
            drive(1'b1, 32'h0);
        end

        base = seen.size();
        for (int k = 0; k < 12; k++) begin
            if (k == 6) repeat (3) drive(1'b0, 32'h7FFFFFFF);
            drive(1'b1, 32'(k) * 32'h8000);
        end
        repeat (6) drive(1'b0, 32'h0);
        chk("decim_count", 32'(seen.size() - base), 32'd3);
        for (int i = 0; i < 3; i++)
            if (base + i < seen.size()) chk("decim_data", 32'(seen[base + i]), 32'(i * 4));

        drive(1'b1, 32'h7FFFFFFF);
        drive(1'b1, 32'h0);
        chk("sat_hi", 32'(out_data), 32'(SAT_HI));
        drive(1'b1, 32'h0);
        drive(1'b1, 32'h0);
        drive(1'b1, 32'h80000000);
        drive(1'b1, 32'h0);
        chk("sat_lo", 32'(out_data), 32'(SAT_LO));
        drive(1'b1, 32'h0);
        drive(1'b1, 32'h0);

        out_ready = 1'b0;
        for (int n = 1; n <= 9; n++) begin
            drive(1'b1, 32'(n << 15));
            repeat (3) drive(1'b1, 32'h0);
        end
        chk("full_level", 32'(fifo_level), 32'd8);
        chk("full_overflow", 32'(overflow), 32'd1);
        base = seen.size();
        out_ready = 1'b1;
        repeat (10) drive(1'b0, 32'h0);
        chk_seen("full_drain", base, 1, 8);

        out_ready = 1'b0;
        for (int n = 1; n <= 5; n++) begin
            drive(1'b1, 32'((n + 20) << 15));
            repeat (3) drive(1'b1, 32'h0);
        end
        chk("pre_reset_level", 32'(fifo_level), 32'd5);
        En_DEC = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_fifo_level", 32'(fifo_level), 32'd0);
        chk("async_overflow", 32'(overflow), 32'd0);
        model_clear();
        @(posedge CLK);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1'b1, 32'(3 << 15));
        drive(1'b1, 32'h0);
        chk("post_reset_valid", 32'(out_valid), 32'd1);
        chk("post_reset_data", 32'(out_data), 32'd3);
        drive(1'b1, 32'h0);
        drive(1'b1, 32'h0);

        out_ready = 1'b0;
        for (int n = 10; n <= 17; n++) begin
            drive(1'b1, 32'(n << 15));
            repeat (3) drive(1'b1, 32'h0);
        end
        chk("simul_pre_level", 32'(fifo_level), 32'd8);
        base = seen.size();
        drive(1'b1, 32'(18 << 15));
        out_ready = 1'b1;
        drive(1'b0, 32'h0);
        out_ready = 1'b0;
        chk("simul_level", 32'(fifo_level), 32'd8);
        chk("simul_overflow", 32'(overflow), 32'd0);
        out_ready = 1'b1;
        repeat (10) drive(1'b0, 32'h0);
        chk_seen("simul_drain", base, 10, 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
